// File: rtl/regfile_read_port.sv
// Register file with one write port and two registered read ports; XZR (top index) reads as zero.
// Latency: 1 cycle from rd_en to rd_data_a/b with rd_valid set.
// Backpressure: rd_en=0 stalls the read side; outputs hold and rd_valid drops.
// Optional: define REGFILE_BYPASS_EN so a same-edge write to the read index returns the new data.
module regfile_read_port #(
    parameter int REG_SIZE = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [REG_SIZE-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [REG_SIZE-1:0] rd_data_a,
    output logic [REG_SIZE-1:0] rd_data_b,
    output logic                rd_valid
);

    // Architectural storage; the XZR slot exists but is never written.
    logic [REG_SIZE-1:0] regs [NUM_REGS];

    logic [REG_SIZE-1:0] val_a;
    logic [REG_SIZE-1:0] val_b;

    // XZR and any index beyond the implemented registers behave as a hardwired zero.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return 32'(addr) >= 32'(NUM_REGS - 1);
    endfunction

    // Write port: reset clears every register; writes to zero-register indices are dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !is_zero_reg(wr_addr)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Port A lookup: zero mask first, then stored value, optionally overridden by a same-edge write.
    always_comb begin
        val_a = '0;
        if (!is_zero_reg(rd_addr_a)) begin
            val_a = regs[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_a)) begin
                val_a = wr_data;
            end
`endif
        end
    end

    // Port B lookup: resolves exactly like port A, independently.
    always_comb begin
        val_b = '0;
        if (!is_zero_reg(rd_addr_b)) begin
            val_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr_b)) begin
                val_b = wr_data;
            end
`endif
        end
    end

    // Read output registers: capture on rd_en, hold data on stall, valid tracks the request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data_a <= val_a;
                rd_data_b <= val_b;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: reset, write/read, XZR, same-edge hit, stall, reset priority.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants; the same-edge hit expectation follows REGFILE_BYPASS_EN.
module tb_regfile_read_port;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic        rd_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    regfile_read_port #(.REG_SIZE(64), .NUM_REGS(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_valid  (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hABCD;
        rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        tick();
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", rd_valid); end
        tests_run++; if (rd_data_a !== 64'h0) begin tests_failed++; $display("FAIL reset_data_a got %h exp 0", rd_data_a); end
        idle(); rd_en = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd7;
        tick();
        tests_run++; if (rd_data_a !== 64'h0) begin tests_failed++; $display("FAIL post_reset_a got %h exp 0", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h0) begin tests_failed++; $display("FAIL post_reset_b got %h exp 0", rd_data_b); end
        tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL post_reset_valid got %0b exp 1", rd_valid); end
    endtask

    task automatic test_write_read();
        idle(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
        tick();
        idle(); rd_en = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        tick();
        tests_run++; if (rd_data_a !== 64'hDEAD_BEEF_0000_0001) begin tests_failed++; $display("FAIL wr_rd_a got %h exp deadbeef00000001", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'hDEAD_BEEF_0000_0001) begin tests_failed++; $display("FAIL wr_rd_b_same_addr got %h exp deadbeef00000001", rd_data_b); end
        tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL wr_rd_valid got %0b exp 1", rd_valid); end
    endtask

    task automatic test_xzr();
        idle(); wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        wr_addr = 5'd30; wr_data = 64'h3030;
        tick();
        idle(); rd_en = 1'b1; rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        tick();
        tests_run++; if (rd_data_a !== 64'h0) begin tests_failed++; $display("FAIL xzr_a got %h exp 0", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h0) begin tests_failed++; $display("FAIL xzr_b got %h exp 0", rd_data_b); end
        rd_addr_a = 5'd30; rd_addr_b = 5'd31;
        tick();
        tests_run++; if (rd_data_a !== 64'h3030) begin tests_failed++; $display("FAIL x30_a got %h exp 3030", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h0) begin tests_failed++; $display("FAIL xzr_b2 got %h exp 0", rd_data_b); end
    endtask

    task automatic test_bypass();
        logic [63:0] exp_hit;
`ifdef REGFILE_BYPASS_EN
        exp_hit = 64'h1234;
`else
        exp_hit = 64'h55;
`endif
        idle(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h55;
        tick();
        wr_data = 64'h1234; rd_en = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd9;
        tick();
        tests_run++; if (rd_data_a !== exp_hit) begin tests_failed++; $display("FAIL same_edge_a got %h exp %h", rd_data_a, exp_hit); end
        tests_run++; if (rd_data_b !== exp_hit) begin tests_failed++; $display("FAIL same_edge_b got %h exp %h", rd_data_b, exp_hit); end
        idle(); rd_en = 1'b1; rd_addr_a = 5'd9; rd_addr_b = 5'd5;
        tick();
        tests_run++; if (rd_data_a !== 64'h1234) begin tests_failed++; $display("FAIL after_hit_a got %h exp 1234", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'hDEAD_BEEF_0000_0001) begin tests_failed++; $display("FAIL after_hit_b got %h exp deadbeef00000001", rd_data_b); end
    endtask

    task automatic test_stall();
        idle(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hA;
        tick();
        idle(); rd_en = 1'b1; rd_addr_a = 5'd2; rd_addr_b = 5'd9;
        tick();
        tests_run++; if (rd_data_a !== 64'hA) begin tests_failed++; $display("FAIL stall_pre_a got %h exp a", rd_data_a); end
        for (int i = 0; i < 3; i++) begin
            idle(); wr_en = 1'b1; wr_addr = 5'd2; wr_data = 64'hB; rd_addr_a = 5'd5;
            tick();
            tests_run++; if (rd_data_a !== 64'hA) begin tests_failed++; $display("FAIL stall_hold_a[%0d] got %h exp a", i, rd_data_a); end
            tests_run++; if (rd_data_b !== 64'h1234) begin tests_failed++; $display("FAIL stall_hold_b[%0d] got %h exp 1234", i, rd_data_b); end
            tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_valid[%0d] got %0b exp 0", i, rd_valid); end
        end
        idle(); rd_en = 1'b1; rd_addr_a = 5'd2;
        tick();
        tests_run++; if (rd_data_a !== 64'hB) begin tests_failed++; $display("FAIL stall_resume_a got %h exp b", rd_data_a); end
    endtask

    task automatic test_back_to_back();
        idle(); wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'h1010;
        tick();
        wr_addr = 5'd11; wr_data = 64'h1111; rd_en = 1'b1; rd_addr_a = 5'd10; rd_addr_b = 5'd2;
        tick();
        tests_run++; if (rd_data_a !== 64'h1010) begin tests_failed++; $display("FAIL b2b0_a got %h exp 1010", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'hB) begin tests_failed++; $display("FAIL b2b0_b got %h exp b", rd_data_b); end
        wr_en = 1'b0; rd_addr_a = 5'd11; rd_addr_b = 5'd10;
        tick();
        tests_run++; if (rd_data_a !== 64'h1111) begin tests_failed++; $display("FAIL b2b1_a got %h exp 1111", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h1010) begin tests_failed++; $display("FAIL b2b1_b got %h exp 1010", rd_data_b); end
        tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b1_valid got %0b exp 1", rd_valid); end
    endtask

    task automatic test_reset_wins();
        idle(); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h77;
        tick();
        reset = 1'b0; wr_data = 64'h99; rd_en = 1'b1; rd_addr_a = 5'd4; rd_addr_b = 5'd4;
        tick();
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_wins_valid got %0b exp 0", rd_valid); end
        tests_run++; if (rd_data_a !== 64'h0) begin tests_failed++; $display("FAIL rst_wins_a got %h exp 0", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h0) begin tests_failed++; $display("FAIL rst_wins_b got %h exp 0", rd_data_b); end
        idle(); rd_en = 1'b1; rd_addr_a = 5'd4; rd_addr_b = 5'd5;
        tick();
        tests_run++; if (rd_data_a !== 64'h0) begin tests_failed++; $display("FAIL rst_x4 got %h exp 0", rd_data_a); end
        tests_run++; if (rd_data_b !== 64'h0) begin tests_failed++; $display("FAIL rst_x5 got %h exp 0", rd_data_b); end
        tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_read_valid got %0b exp 1", rd_valid); end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        tick();
        test_reset();
        test_write_read();
        test_xzr();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_reset_wins();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
